// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encodings and flag bit positions.
package alu_pkg;

    localparam int OP_SUB        = 0;
    localparam int OP_NAND       = 1;
    localparam int OP_START_ONES = 2;
    localparam int OP_ONEHOT_DEC = 3;

    localparam int FLAG_ERR      = 0;
    localparam int FLAG_NEG      = 1;
    localparam int FLAG_POS      = 2;
    localparam int FLAG_OVERFLOW = 3;
    localparam int FLAG_W        = 4;

endpackage

// File: rtl/alu_core.sv
// Combinational ALU datapath: result and flag generation for one opcode.
module alu_core
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN   = 2
) (
    input  logic [WIDTH-1:0]  i_a,
    input  logic [WIDTH-1:0]  i_b,
    input  logic [LEN-1:0]    i_oper,
    output logic [WIDTH-1:0]  o_result,
    output logic [FLAG_W-1:0] o_flag
);

    logic [WIDTH-1:0] res;
    logic [WIDTH-1:0] ones;
    logic [WIDTH-1:0] idx;
    logic             run;
    logic             onehot;
    logic             err;
    logic             ovf;

    // Leading-ones run length, scanning down from the MSB.
    always_comb begin
        ones = '0;
        run  = 1'b1;
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (run && i_a[i]) begin
                ones = ones + WIDTH'(1);
            end else begin
                run = 1'b0;
            end
        end
    end

    always_comb begin
        idx = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (i_a[i]) begin
                idx = WIDTH'(i);
            end
        end
    end

    assign onehot = (i_a != '0) && ((i_a & (i_a - WIDTH'(1))) == '0);

    always_comb begin
        res = '0;
        err = 1'b0;
        ovf = 1'b0;
        case (i_oper)
            LEN'(OP_SUB): begin
                res = i_a - i_b;
                ovf = (i_a[WIDTH-1] ^ i_b[WIDTH-1])
                    & (res[WIDTH-1] ^ i_a[WIDTH-1]);
            end
            LEN'(OP_NAND):       res = ~(i_a & i_b);
            LEN'(OP_START_ONES): res = ones;
            LEN'(OP_ONEHOT_DEC): begin
                if (onehot) begin
                    res = idx;
                end else begin
                    err = 1'b1;
                end
            end
            default:             err = 1'b1;
        endcase
    end

    // An error suppresses every other flag.
    always_comb begin
        o_result = res;
        o_flag   = '0;
        o_flag[FLAG_ERR] = err;
        if (!err) begin
            o_flag[FLAG_NEG]      = res[WIDTH-1];
            o_flag[FLAG_POS]      = (res != '0) && !res[WIDTH-1];
            o_flag[FLAG_OVERFLOW] = ovf;
        end
    end

endmodule

// File: rtl/alu_top.sv
// Registered ALU: one-cycle latency wrapper around alu_core.
module alu_top
    import alu_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int LEN   = 2
) (
    input  logic              i_clk,
    input  logic              i_rstn,
    input  logic [WIDTH-1:0]  i_arg0,
    input  logic [WIDTH-1:0]  i_arg1,
    input  logic [LEN-1:0]    i_oper,
    output logic [WIDTH-1:0]  o_result,
    output logic [FLAG_W-1:0] o_flag
);

    logic [WIDTH-1:0]  core_result;
    logic [FLAG_W-1:0] core_flag;
    logic [WIDTH-1:0]  result_d;
    logic [WIDTH-1:0]  result_q;
    logic [FLAG_W-1:0] flag_d;
    logic [FLAG_W-1:0] flag_q;

    alu_core #(
        .WIDTH (WIDTH),
        .LEN   (LEN)
    ) u_core (
        .i_a      (i_arg0),
        .i_b      (i_arg1),
        .i_oper   (i_oper),
        .o_result (core_result),
        .o_flag   (core_flag)
    );

    always_comb begin
        result_d = core_result;
        flag_d   = core_flag;
    end

    // Reset is active-high despite the port name.
    always_ff @(posedge i_clk or posedge i_rstn) begin
        if (i_rstn) begin
            result_q <= '0;
            flag_q   <= '0;
        end else begin
            result_q <= result_d;
            flag_q   <= flag_d;
        end
    end

    assign o_result = result_q;
    assign o_flag   = flag_q;

endmodule

// File: tb/tb_alu_top.sv
// Scoreboard bench for alu_top: directed vectors, mid-cycle reset, random vectors.
module tb_alu_top;

    logic       clk;
    logic       rst;
    logic [3:0] a;
    logic [3:0] b;
    logic [1:0] op;
    logic [3:0] result;
    logic [3:0] flag;

    int checks   = 0;
    int failures = 0;

    logic [7:0] exp_q[$];
    string      name_q[$];

    alu_top #(
        .WIDTH (4),
        .LEN   (2)
    ) dut (
        .i_clk    (clk),
        .i_rstn   (rst),
        .i_arg0   (a),
        .i_arg1   (b),
        .i_oper   (op),
        .o_result (result),
        .o_flag   (flag)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {flags[3:0], result[3:0]}, flags = {OVF,POS,NEG,ERR}.
    function automatic logic [7:0] model(int ai, int bi, int opi);
        int r;
        int sa;
        int sb;
        int sd;
        int k;
        bit e;
        bit v;
        logic [3:0] f;
        r = 0;
        e = 0;
        v = 0;
        case (opi)
            0: begin
                sa = (ai >= 8) ? ai - 16 : ai;
                sb = (bi >= 8) ? bi - 16 : bi;
                sd = sa - sb;
                v  = (sd < -8) || (sd > 7);
                r  = (sd + 32) % 16;
            end
            1: r = 15 - (ai & bi);
            2: begin
                k = 3;
                while (k >= 0 && ((ai >> k) & 1) == 1) begin
                    r = r + 1;
                    k = k - 1;
                end
            end
            default: begin
                case (ai)
                    1: r = 0;
                    2: r = 1;
                    4: r = 2;
                    8: r = 3;
                    default: e = 1;
                endcase
            end
        endcase
        f = 4'b0000;
        if (e) begin
            f = 4'b0001;
        end else begin
            f[1] = (r >= 8);
            f[2] = (r != 0) && (r < 8);
            f[3] = v;
        end
        return {f, 4'(r)};
    endfunction

    task automatic drive(input logic [3:0] ta, input logic [3:0] tb,
                         input logic [1:0] top, input logic [7:0] expv,
                         input string nm);
        @(negedge clk);
        a  = ta;
        b  = tb;
        op = top;
        exp_q.push_back(expv);
        name_q.push_back(nm);
    endtask

    task automatic check_now(input string nm, input logic [7:0] expv);
        checks++;
        if ({flag, result} !== expv) begin
            failures++;
            $display("FAIL %s: got flag=%b result=%b, want flag=%b result=%b",
                     nm, flag, result, expv[7:4], expv[3:0]);
        end
    endtask

    // Monitor: every output-producing edge consumes one queued expectation.
    initial begin
        logic [7:0] e;
        string      nm;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() != 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                check_now(nm, e);
            end
        end
    end

    initial begin
        int ra;
        int rb;
        int rop;
        int waited;
        rst = 1'b1;
        a   = 4'h0;
        b   = 4'h0;
        op  = 2'b00;
        #1;
        check_now("reset_state", 8'h00);
        @(negedge clk);
        rst = 1'b0;

        drive(4'h5, 4'h3, 2'b00, {4'b0100, 4'h2}, "sub_5_3");
        drive(4'hF, 4'h0, 2'b01, {4'b0010, 4'hF}, "nand_f_0");
        drive(4'h7, 4'h8, 2'b00, {4'b1010, 4'hF}, "sub_ovf_pos");
        drive(4'h8, 4'h5, 2'b00, {4'b1100, 4'h3}, "sub_ovf_neg");
        drive(4'h3, 4'h3, 2'b00, {4'b0000, 4'h0}, "sub_zero");
        drive(4'hC, 4'h3, 2'b10, {4'b0100, 4'h2}, "ones_c");
        drive(4'h7, 4'h9, 2'b10, {4'b0000, 4'h0}, "ones_7");
        drive(4'hF, 4'h0, 2'b10, {4'b0100, 4'h4}, "ones_f");
        drive(4'h2, 4'h8, 2'b11, {4'b0100, 4'h1}, "dec_2");
        drive(4'h8, 4'h1, 2'b11, {4'b0100, 4'h3}, "dec_8");
        drive(4'h1, 4'hF, 2'b11, {4'b0000, 4'h0}, "dec_1");
        drive(4'h6, 4'h0, 2'b11, {4'b0001, 4'h0}, "dec_multi");
        drive(4'h0, 4'h0, 2'b11, {4'b0001, 4'h0}, "dec_zero");
        drive(4'h0, 4'h0, 2'b01, {4'b0010, 4'hF}, "nand_0_0");

        @(negedge clk);
        a  = 4'h5;
        b  = 4'h3;
        op = 2'b00;
        #2;
        rst = 1'b1;
        #1;
        check_now("reset_async", 8'h00);
        @(posedge clk);
        #1;
        check_now("reset_held", 8'h00);
        @(negedge clk);
        rst = 1'b0;
        drive(4'h5, 4'h3, 2'b00, {4'b0100, 4'h2}, "post_reset_first");

        for (int i = 0; i < 50; i++) begin
            ra  = $urandom_range(0, 15);
            rb  = $urandom_range(0, 15);
            rop = $urandom_range(0, 3);
            drive(4'(ra), 4'(rb), 2'(rop), model(ra, rb, rop), "random");
        end

        waited = 0;
        while (exp_q.size() != 0 && waited < 5) begin
            @(negedge clk);
            waited++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain: %0d expectations left, want 0", exp_q.size());
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_top.md
ALU_TOP -- requirements
Module: alu_top

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4, setting the operand and result width in bits (minimum 2).
REQ-002 The block SHALL have parameter LEN, default 2, setting the opcode width in bits.
REQ-003 The block SHALL use one clock and an asynchronous, active-high reset.
REQ-004 Port i_clk SHALL be an input of width 1 carrying the single clock; all state SHALL update on its rising edge.
REQ-005 Port i_rstn SHALL be an input of width 1 carrying the asynchronous reset; it is asserted at logic 1, despite the n suffix.
REQ-006 Port i_arg0 SHALL be an input of width WIDTH carrying operand A.
REQ-007 Port i_arg1 SHALL be an input of width WIDTH carrying operand B.
REQ-008 Port i_oper SHALL be an input of width LEN carrying the operation select.
REQ-009 Port o_result SHALL be an output of width WIDTH carrying the registered result.
REQ-010 Port o_flag SHALL be an output of width 4 carrying the registered flags: bit0 ERR, bit1 NEG, bit2 POS, bit3 OVERFLOW.

Function
REQ-011 Inputs SHALL be sampled on each rising i_clk edge; o_result and o_flag SHALL update at that edge and hold until the next edge, giving 1-cycle latency with no handshake.
REQ-012 Opcode 00 (subtract) SHALL compute A-B as two's complement, truncated to WIDTH bits with wrap-around.
REQ-013 For subtract, OVERFLOW SHALL be 1 when A and B differ in sign and the result sign differs from A's sign, else 0.
REQ-014 Opcode 01 (nand) SHALL compute the bitwise NOT of (A AND B).
REQ-015 Opcode 10 (starting ones) SHALL output, unsigned, the count of consecutive 1 bits in A starting at the MSB (range 0..WIDTH); B SHALL be ignored.
REQ-016 Opcode 11 (one-hot decoder) SHALL output the bit index (0..WIDTH-1) of the single set bit of A, as a non-negative two's-complement value; B SHALL be ignored.
REQ-017 For opcode 11, if A is zero or has more than one bit set, o_result SHALL be 0 and ERR SHALL be 1.
REQ-018 When ERR is 0, NEG SHALL equal result[WIDTH-1], and POS SHALL be 1 when the result is nonzero with MSB 0; a zero result SHALL give NEG=0 and POS=0.
REQ-019 When ERR is 1, NEG, POS and OVERFLOW SHALL be 0.
REQ-020 OVERFLOW SHALL be 0 for opcodes 01, 10 and 11; ERR SHALL be 0 for opcodes 00, 01 and 10.
REQ-021 If LEN > 2, opcode values above 3 SHALL produce result 0 with ERR=1.

Reset
REQ-022 While i_rstn=1, o_result and o_flag SHALL be all zeros, taking effect immediately and independent of i_clk.
REQ-023 Reset asserted mid-operation SHALL discard any in-flight result.
REQ-024 After reset is released, the first valid output SHALL appear at the first rising edge that samples inputs with reset low.

Structure
REQ-025 A shared package alu_pkg SHALL hold the opcode constants (OP_SUB, OP_NAND, OP_START_ONES, OP_ONEHOT_DEC) and the flag bit-position constants (FLAG_ERR=0, FLAG_NEG=1, FLAG_POS=2, FLAG_OVERFLOW=3).
REQ-026 The block SHALL contain one combinational sub-module, alu_core, that computes the result and flags; alu_top SHALL contain only the output registers and reset.

Verification
REQ-027 A=0101, B=0011, op=00 SHALL give, one cycle later, result=0010 and flags ERR=0, NEG=0, POS=1, OVF=0.
REQ-028 A=1111, B=0000, op=01 SHALL give result=1111 with NEG=1; A=0111, B=1000, op=00 SHALL give result=1111 with OVF=1 and NEG=1.
REQ-029 A=1100, B=0011, op=10 SHALL give result=0010 (POS=1); A=0111, op=10 SHALL give 0000 with POS=0 and NEG=0; A=1111, op=10 SHALL give 0100.
REQ-030 A=0010, B=1000, op=11 SHALL give result=0001 (POS=1); A=0110, op=11 SHALL give result=0000 with ERR=1.
REQ-031 Asserting i_rstn between clock edges SHALL clear the outputs to 0 at once; the bench SHALL then apply 50 random A/B/op vectors and compare each against a reference model delayed by one cycle.
